// File: rtl/tetris_line_clear_ctrl.sv
// Row-compaction controller: walks the grid bottom-to-top, drops full rows, shifts survivors down, zero-fills the top.
// Latency: start to done is ROWS+1+k cycles (k = rows cleared); at most one row read and one row write per cycle.
// Backpressure: none; start is ignored while busy. Optional score accumulator under macro LINE_CLEAR_SCORE_EN.
module tetris_line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  output logic [$clog2(ROWS)-1:0]    rd_row,
  input  logic [COLS*CW-1:0]         rd_data,
  output logic                       wr_en,
  output logic [$clog2(ROWS)-1:0]    wr_row,
  output logic [COLS*CW-1:0]         wr_data,
  output logic [15:0]                score
);
  localparam int RW = $clog2(ROWS);
  localparam int KW = $clog2(ROWS+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] w_q, w_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] lines_q, lines_d;
  logic          row_full;

  // A row is full when no cell of the current read holds colour 0.
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (rd_data[c*CW +: CW] == '0) row_full = 1'b0;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      w_q     <= '0;
      k_q     <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      k_q     <= k_d;
      lines_q <= lines_d;
    end
  end

  // Next state and pointer updates; w only moves past a row once it has been kept.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    w_d     = w_q;
    k_d     = k_q;
    lines_d = lines_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          r_d     = LAST_ROW;
          w_d     = LAST_ROW;
          k_d     = '0;
          lines_d = '0;
        end
      end
      SCAN: begin
        r_d = r_q - 1'b1;
        if (row_full) k_d = k_q + 1'b1;
        else          w_d = w_q - 1'b1;
        if (r_q == '0) state_d = (k_d != '0) ? FILL : DONE;
      end
      FILL: begin
        w_d = w_q - 1'b1;
        if (w_q == '0) state_d = DONE;
      end
      DONE: begin
        lines_d = k_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; kept rows are copied only when they actually move.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    lines_cleared = (state_q == DONE) ? k_q : lines_q;
    rd_row        = '0;
    wr_en         = 1'b0;
    wr_row        = '0;
    wr_data       = '0;
    case (state_q)
      SCAN: begin
        rd_row = r_q;
        if (!row_full && (w_q != r_q)) begin
          wr_en   = 1'b1;
          wr_row  = w_q;
          wr_data = rd_data;
        end
      end
      FILL: begin
        wr_en  = 1'b1;
        wr_row = w_q;
      end
      default: ;
    endcase
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;
  logic [10:0] points;

  // Classic line-clear points with a saturating accumulator, updated on the DONE cycle.
  always_comb begin
    case (k_q)
      KW'(0):  points = 11'd0;
      KW'(1):  points = 11'd40;
      KW'(2):  points = 11'd100;
      KW'(3):  points = 11'd300;
      default: points = 11'd1200;
    endcase
    score_sum = {1'b0, score_q} + {6'd0, points};
    score_d   = score_q;
    if (state_q == DONE) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif
endmodule

// File: tb/tb_tetris_line_clear_ctrl.sv
// Bench for tetris_line_clear_ctrl: owns a grid model, runs directed table scenarios and random grids
// against a queue-based compaction model, plus reset and start-while-busy sequences.
// Score expectations follow LINE_CLEAR_SCORE_EN when defined, otherwise score must stay 0.
module tb_tetris_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int RUN_CYC = 45;

  typedef logic [COLS*CW-1:0] row_t;

  typedef struct {
    int  kind;
    bit  extra_start;
    int  exp_lines;
    int  exp_lat;
    int  exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, wr_en;
  logic [4:0]  lines_cleared;
  logic [4:0]  rd_row, wr_row;
  row_t        rd_data, wr_data;
  logic [15:0] score;

  row_t grid [ROWS];
  row_t load_grid [ROWS];
  row_t exp_grid [ROWS];
  logic load_req = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int exp_score = 0;
  int exp_k, exp_wr;

  tetris_line_clear_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .rd_row(rd_row), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .score(score)
  );

  always #5 clk = ~clk;

  assign rd_data = grid[rd_row];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < ROWS; i++) grid[i] <= load_grid[i];
    end else if (wr_en) begin
      grid[wr_row] <= wr_data;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_full(input row_t row);
    for (int c = 0; c < COLS; c++) if (row[c*CW +: CW] == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic row_t uniform_row(input int colour);
    row_t r = '0;
    for (int c = 0; c < COLS; c++) r[c*CW +: CW] = colour[2:0];
    return r;
  endfunction

  function automatic row_t rand_row(input bit full);
    row_t r = '0;
    for (int c = 0; c < COLS; c++)
      r[c*CW +: CW] = full ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
    return r;
  endfunction

  function automatic int points(input int k);
    case (k)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  // Reference: keep non-full rows in bottom-to-top order, stack them from the bottom, zero the rest.
  task automatic model();
    row_t kept[$];
    int   dest [$];
    kept = {};
    dest = {};
    exp_wr = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!is_full(load_grid[i])) begin
        kept.push_back(load_grid[i]);
        if ((ROWS - kept.size()) != i) exp_wr++;
      end
    end
    exp_k = ROWS - kept.size();
    exp_wr += exp_k;
    for (int i = 0; i < ROWS; i++) exp_grid[i] = '0;
    for (int j = 0; j < kept.size(); j++) exp_grid[ROWS - 1 - j] = kept[j];
  endtask

  task automatic load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic build(input int kind);
    for (int i = 0; i < ROWS; i++) load_grid[i] = '0;
    case (kind)
      1: begin
        load_grid[19] = uniform_row(2);
        load_grid[18] = row_t'(3);
      end
      2: begin
        for (int i = 16; i < 20; i++) load_grid[i] = rand_row(1'b1);
        load_grid[15] = row_t'(30'h0000_1234);
      end
      3: begin
        load_grid[19] = uniform_row(5);
        load_grid[17] = rand_row(1'b1);
        load_grid[18] = row_t'(30'h0000_0001);
        load_grid[16] = row_t'(30'h0000_002A);
      end
      4: begin
        load_grid[19] = uniform_row(1);
        load_grid[19][9*CW +: CW] = 3'd0;
      end
      default: ;
    endcase
    load();
  endtask

  // One compaction: start, observe a fixed window, compare against the model.
  task automatic run_one(input bit extra, output int lat, output int k_seen, output int nwr);
    int dones, bad_idle, mism, score_before;
    model();
    score_before = exp_score;
    lat = -1; k_seen = -1; dones = 0; nwr = 0; bad_idle = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= RUN_CYC; cyc++) begin
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (wr_en) nwr++;
      else if (wr_data != '0) bad_idle++;
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = cyc;
          k_seen = lines_cleared;
          check("lines_at_done", lines_cleared, exp_k);
          check("score_at_done", score, score_before);
`ifdef LINE_CLEAR_SCORE_EN
          exp_score = exp_score + points(exp_k);
          if (exp_score > 65535) exp_score = 65535;
`endif
        end
      end
      if (lat > 0 && cyc == lat + 1) check("score_after_done", score, exp_score);
      start = (extra && cyc == 5) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    mism = 0;
    for (int i = 0; i < ROWS; i++) if (grid[i] !== exp_grid[i]) mism++;
    check("done_pulses", dones, 1);
    check("latency", lat, ROWS + 1 + exp_k);
    check("write_count", nwr, exp_wr);
    check("wr_data_idle_zero", bad_idle, 0);
    check("grid_rows_wrong", mism, 0);
    check("lines_hold", lines_cleared, exp_k);
    check("busy_idle", busy, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int lat, k, nwr, dones;
    vecs[0] = '{kind: 0, extra_start: 1'b0, exp_lines: 0, exp_lat: 21, exp_wr: 0};
    vecs[1] = '{kind: 1, extra_start: 1'b0, exp_lines: 1, exp_lat: 22, exp_wr: 20};
    vecs[2] = '{kind: 2, extra_start: 1'b0, exp_lines: 4, exp_lat: 25, exp_wr: 20};
    vecs[3] = '{kind: 3, extra_start: 1'b0, exp_lines: 2, exp_lat: 23, exp_wr: 20};
    vecs[4] = '{kind: 4, extra_start: 1'b0, exp_lines: 0, exp_lat: 21, exp_wr: 0};
    vecs[5] = '{kind: 0, extra_start: 1'b1, exp_lines: 0, exp_lat: 21, exp_wr: 0};

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < ROWS; i++) load_grid[i] = '0;
    load();
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_rd_row", rd_row, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_row", wr_row, 0);
    check("rst_wr_data", int'(wr_data != '0), 0);
    check("rst_score", score, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      build(vecs[v].kind);
      run_one(vecs[v].extra_start, lat, k, nwr);
      check($sformatf("vec%0d_lines", v), k, vecs[v].exp_lines);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_writes", v), nwr, vecs[v].exp_wr);
    end

    // Spot checks of the directed final layouts.
    build(1);
    run_one(1'b0, lat, k, nwr);
    check("one_row_row19", int'(grid[19]), 3);
    check("one_row_row0", int'(grid[0]), 0);
    build(3);
    run_one(1'b0, lat, k, nwr);
    check("noncontig_row19", int'(grid[19]), 32'h1);
    check("noncontig_row18", int'(grid[18]), 32'h2A);
    build(2);
    run_one(1'b0, lat, k, nwr);
    check("four_row19", int'(grid[19]), 32'h1234);

    // Random grids with a mix of full, empty and partial rows.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < ROWS; i++) begin
        case ($urandom_range(0, 3))
          0: load_grid[i] = rand_row(1'b1);
          1: load_grid[i] = '0;
          default: load_grid[i] = rand_row(1'b0);
        endcase
      end
      load();
      run_one(1'b0, lat, k, nwr);
    end

    // Enough tetrises to push the accumulator into saturation.
    for (int t = 0; t < 56; t++) begin
      build(2);
      run_one(1'b0, lat, k, nwr);
    end
`ifdef LINE_CLEAR_SCORE_EN
    check("score_saturated", score, 65535);
`else
    check("score_tied_zero", score, 0);
`endif

    // Reset during SCAN cycle 10: everything drops to zero and no done follows.
    build(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk); #1;
    end
    check("scan_busy_before_reset", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_score = 0;
    check("midrst_busy", busy, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_score", score, 0);
    check("midrst_done", done, 0);
    check("midrst_lines", lines_cleared, 0);
    check("midrst_rd_row", rd_row, 0);
    dones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", dones, 0);

    // Controller recovers normally after the aborted pass.
    build(2);
    run_one(1'b0, lat, k, nwr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tetris_line_clear_ctrl.md
# tetris_line_clear_ctrl

Row-compaction controller for the Tetris playfield. After the game logic locks a piece, it pulses `start`. The block then walks the 20×10 colour grid bottom-to-top through a single-row read/write port, drops every full row, shifts the surviving rows down and zero-fills the top. It sits between the falling-piece logic and the grid register array that the colour mapper reads. It reports the number of lines cleared and, optionally, a running score.

## Interface
- `ROWS`, default 20: playfield rows; row 0 is the top.
- `COLS`, default 10: playfield columns.
- `CW`, default 3: colour bits per cell; value 0 means empty.
- `clk`  in  1: pixel/game clock; the only clock in the block.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request compaction; sampled only in IDLE.
- `busy`  out  1: high in SCAN, FILL and DONE.
- `done`  out  1: one-cycle pulse at the end of a compaction.
- `lines_cleared`  out  $clog2(ROWS+1): number of full rows removed by the last compaction.
- `rd_row`  out  $clog2(ROWS): row address for grid read.
- `rd_data`  in  COLS*CW: combinational grid read of `rd_row`, same cycle; column c sits at bits [c*CW +: CW].
- `wr_en`  out  1: grid row write strobe; the owner commits the write at the next `clk` edge.
- `wr_row`  out  $clog2(ROWS): row address for grid write.
- `wr_data`  out  COLS*CW: row data to write.
- `score`  out  16: accumulated score; constant 0 unless `LINE_CLEAR_SCORE_EN` is defined.

## Operation
- **States:** IDLE, SCAN, FILL, DONE.
- **Internal registers:**
  - read pointer `r`
  - write pointer `w`
  - count `k`
- **IDLE:**
  - `busy`=0 and `rd_row`=0.
  - On `start`=1: load `r`=`w`=ROWS-1, clear `k` and `lines_cleared` to 0, go to SCAN.
- **SCAN, one row per cycle:**
  - `rd_row`=`r`.
  - The row is full when every cell of `rd_data` is nonzero.
  - Full row: `k`++, no write, `w` unchanged.
  - Not full and `w`≠`r`: `wr_en`=1, `wr_row`=`w`, `wr_data`=`rd_data`, then `w`--.
  - Not full and `w`=`r`: no write, `w`--.
  - `r`-- every cycle.
  - After the cycle with `r`=0: go to FILL if `k`>0, otherwise go to DONE.
- **FILL:**
  - Each cycle: `wr_en`=1, `wr_row`=`w`, `wr_data`=0, then `w`--.
  - Leave for DONE after the write to row 0. This takes exactly `k` cycles.
- **DONE:**
  - `done`=1, `lines_cleared`=`k`, go to IDLE.
  - `lines_cleared` holds until the next accepted `start`.
- **Ordering invariant:** `w` ≥ `r` at all times, so a write never targets a row that has not yet been read.
- **Outputs outside SCAN/FILL:** `wr_en`=0 and `wr_data`=0.
- **`start` while `busy`:** ignored; it is not queued.
- **Grid ownership:** the grid owner must not write the grid while `busy`=1. The controller does not check this.
- **Reset, including mid-operation:**
  - Next state is IDLE.
  - All outputs go to 0, including `score`.
  - No `done` pulse is produced.
  - The grid keeps any writes already committed; recovery is the owner's responsibility.

## Timing
- `start` accepted at edge 0.
- SCAN occupies cycles 1..ROWS.
- FILL occupies cycles ROWS+1..ROWS+k.
- DONE occurs at cycle ROWS+k+1.
- The next `start` can be accepted at cycle ROWS+k+2.
- Total latency from `start` to `done`: ROWS+1+k cycles. For the default ROWS=20: 21 cycles with no clear, 25 cycles for a 4-line clear.
- One grid row write per cycle at most; one read per cycle.
- Reset values: `busy`=0, `done`=0, `lines_cleared`=0, `rd_row`=0, `wr_en`=0, `wr_row`=0, `wr_data`=0, `score`=0.

## Configuration
- **Macro:** `LINE_CLEAR_SCORE_EN`.
- **Defined:**
  - In DONE, `score` adds 0/40/100/300/1200 for `k`=0/1/2/3/≥4.
  - The sum saturates at 65535.
  - The updated `score` is visible the cycle after DONE.
- **Not defined:** `score` is tied to 0 and no score logic is generated.

## Test plan
- **Empty grid:** pulse `start` → `wr_en` never asserts; `done` at cycle 21; `lines_cleared`=0; `score`=0.
- **One full row:** row 19 all colour 2; row 18 = colour 3 in column 0 only, rest 0.
  - `start` → row 19 is written with row 18's data; rows 18..0 are shifted down; row 0 is written 0.
  - `done` at cycle 22; `lines_cleared`=1; `score`=40.
- **Four full rows:** rows 16..19 full; row 15 = pattern P.
  - → final row 19 = P; rows 0..3 = 0; `lines_cleared`=4; `done` at cycle 25; `score`=1200.
- **Non-contiguous clears:** rows 19 and 17 full; row 18 = A; row 16 = B.
  - → final row 19 = A; row 18 = B; rows 0..1 = 0; `lines_cleared`=2; `score`=100.
- **Almost-full row:** row 19 full except column 9 = 0 → no write is issued for row 19; `lines_cleared`=0.
- **Control hazards:**
  - Extra `start` pulse at cycle 5 → ignored; a single `done` at cycle 21.
  - `reset` asserted during SCAN cycle 10 → next cycle `busy`=0, `wr_en`=0, `score`=0; no `done` pulse.
